// File: rtl/operand_sequencer_pkg.sv
// Shared types for operand_sequencer: FSM states, mode encodings and the per-width LFSR tap table.
// Tap masks are 0-indexed bit positions XORed into the LSB of a shift-left Fibonacci LFSR.
package operand_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_COUNTER = 1'b0;
  localparam logic MODE_LFSR    = 1'b1;

  // Maximal-length tap sets for widths 3..16.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/opseq_lfsr.sv
// One combinational LFSR step: shift left, feedback from the package tap table into bit 0.
// Zero latency (pure combinational); no flow control of its own.
module opseq_lfsr
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_cur,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [15:0] TAPS = lfsr_taps(WIDTH);

  logic [WIDTH-1:0] w_mask;
  logic             w_fb;

  assign w_mask = TAPS[WIDTH-1:0];
  assign w_fb   = ^(i_cur & w_mask);
  assign o_next = {i_cur[WIDTH-2:0], w_fb};

endmodule

// File: rtl/operand_sequencer.sv
// Emits SEQ_LEN (A,B,OP) beats per run; first beat valid the cycle after start, one beat per transfer.
// Operands hold while out_ready=0. LFSR mode exists only with OPERAND_SEQUENCER_LFSR_EN defined.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int NUM_OPS = 2,
  parameter int SEQ_LEN = 8,
  parameter int A_SEED  = 0,
  parameter int B_SEED  = 2**WIDTH-1,
  localparam int OP_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OP_W-1:0]  OP,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] A_SEED_V = WIDTH'(A_SEED);
  localparam logic [WIDTH-1:0] B_SEED_V = WIDTH'(B_SEED);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(NUM_OPS - 1);
  localparam logic [15:0]      CNT_LAST = 16'(SEQ_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] w_a_step;
  logic [WIDTH-1:0] w_b_step;
  logic [WIDTH-1:0] w_a_load;
  logic [WIDTH-1:0] w_b_load;
  logic             w_xfer;
  logic             w_launch;
  logic             w_last;

  // stop takes priority, so a start in the same cycle does not launch
  assign w_launch = (r_state == S_IDLE) && start && !stop;
  assign w_xfer   = (r_state == S_RUN) && out_ready;
  assign w_last   = (r_cnt == CNT_LAST);

`ifdef OPERAND_SEQUENCER_LFSR_EN
  logic             r_mode;
  logic [WIDTH-1:0] w_a_lfsr;
  logic [WIDTH-1:0] w_b_lfsr;

  opseq_lfsr #(.WIDTH(WIDTH)) u_lfsr_a (.i_cur(r_a), .o_next(w_a_lfsr));
  opseq_lfsr #(.WIDTH(WIDTH)) u_lfsr_b (.i_cur(r_b), .o_next(w_b_lfsr));

  assign w_a_step = (r_mode == MODE_LFSR) ? w_a_lfsr : r_a + 1'b1;
  assign w_b_step = (r_mode == MODE_LFSR) ? w_b_lfsr : r_b - 1'b1;
  // An all-zero LFSR state is a lock-up point, so a zero seed starts at 1.
  assign w_a_load = ((mode == MODE_LFSR) && (A_SEED_V == '0)) ? WIDTH'(1) : A_SEED_V;
  assign w_b_load = ((mode == MODE_LFSR) && (B_SEED_V == '0)) ? WIDTH'(1) : B_SEED_V;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_COUNTER;
    end else if (w_launch) begin
      r_mode <= mode;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_a_step      = r_a + 1'b1;
  assign w_b_step      = r_b - 1'b1;
  assign w_a_load      = A_SEED_V;
  assign w_b_load      = B_SEED_V;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A transfer coinciding with stop still advances the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
    end else if (w_launch) begin
      r_a   <= w_a_load;
      r_b   <= w_b_load;
      r_op  <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 16'd1;
      if (r_op == OP_LAST) begin
        r_op <= '0;
        r_a  <= w_a_step;
        r_b  <= w_b_step;
      end else begin
        r_op <= r_op + 1'b1;
      end
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign OP        = r_op;
  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule
